exu_issue_ctrl: RTL and testbench
=================================

// Module: exu_issue_ctrl
// PURPOSE
//  Parametrised execute-stage issue/writeback controller. Accepts one decoded instruction from IDU over a
//  valid/ready handshake and holds its fields. Issues it to one of NUM_FU functional units (ALU/LSU/SYS...)
//  and waits for that unit's completion. Performs the single GPR write (W-op sign-extension, x0 suppression)
//  and pulses ifetch_req. Replaces the fixed-priority, no-backpressure EXU glue with a stateful controller.
// PARAMETERS
//  XLEN         64    datapath width
//  REG_AW       5     GPR address width
//  NUM_FU       3     number of functional units (index 0=ALU, 1=LSU, 2=SYS)
//  TIMEOUT_CYC  1024  watchdog limit in WAIT (used only with EXU_TIMEOUT_EN)
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              reset, asynchronous, active-low
//  idu_vld      in   1              IDU instruction valid
//  idu_rdy      out  1              controller can accept
//  idu_rd       in   REG_AW         destination register
//  idu_dst_vld  in   1              instruction writes rd
//  idu_w_inst   in   1              32-bit W-op: sign-extend result bit 31
//  idu_fu_sel   in   NUM_FU         one-hot target unit
//  idu_pc       in   XLEN           instruction PC
//  fu_req       out  NUM_FU         one-cycle issue pulse to selected unit
//  fu_pc        out  XLEN           held PC of the in-flight instruction
//  fu_done      in   NUM_FU         unit completion pulse
//  fu_wb_data   in   NUM_FU*XLEN    unit results, unit i at [i*XLEN +: XLEN]
//  rf_wen       out  1              GPR write enable
//  rf_waddr     out  REG_AW         GPR write address
//  rf_wdata     out  XLEN           GPR write data
//  ifetch_req   out  1              instruction retired; IFU may fetch next
//  ill_sel      out  1              pulse: idu_fu_sel was not one-hot
//  exu_err      out  1              pulse: watchdog abort (0 without EXU_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, idu_rdy=1, all other outputs 0, held fields 0. Reset mid-operation drops the instruction; no write.
//  FSM IDLE -> ISSUE -> WAIT -> WB -> IDLE. idu_rdy=1 only in IDLE.
//  IDLE: on idu_vld&idu_rdy (cycle 0), latch rd/dst_vld/w_inst/fu_sel/pc; go to ISSUE.
//  - fu_sel not one-hot (zero or >1 bits): go to WB with no write; ill_sel pulses alongside ifetch_req.
//  ISSUE (cycle 1): fu_req=fu_sel_r for exactly this cycle, then WAIT.
//  - fu_done[sel] in this same cycle is accepted (0-latency unit): capture data, go to WB, skip WAIT.
//  WAIT: hold until fu_done[sel]; capture fu_wb_data slice into a result register, go to WB.
//  - fu_done on non-selected units is ignored in every state.
//  WB (done cycle+1): ifetch_req=1 for one cycle.
//  - rf_wen=1 iff dst_vld_r && rd_r!=0 && !ill; rf_waddr=rd_r.
//  - rf_wdata = w_inst_r ? {{(XLEN-32){res[31]}},res[31:0]} : res; rf_wdata=0 whenever rf_wen=0.
//  - Then IDLE. Min accept-to-accept interval: 3 cycles (0-latency FU).
//  fu_pc is valid from ISSUE until WB.
// CONFIGURATION
//  EXU_TIMEOUT_EN defined:
//  - counter cleared on entering WAIT, increments each WAIT cycle.
//  - at count==TIMEOUT_CYC-1 without fu_done: go to WB, no write, exu_err and ifetch_req pulse together.
//  - fu_done in the same cycle as expiry wins (normal completion, no exu_err).
//  EXU_TIMEOUT_EN undefined: no counter; WAIT is unbounded; exu_err tied 0.
// STRUCTURE
//  exu_pkg: exu_state_e enum {IDLE,ISSUE,WAIT,WB}; FU index constants FU_ALU=0, FU_LSU=1, FU_SYS=2.
//  Sub-module exu_wb_mux: one-hot select of the fu_wb_data slice + W-op sign-extension, combinational.
// TESTING
//  ALU add, fu_done in ISSUE, rd=5, res=64'h1 -> rf_wen @cycle2, waddr=5, wdata=1, ifetch_req same cycle.
//  LSU load, done 7 cycles after fu_req, w_inst=1, res=64'h0000_0000_8000_0000 -> wdata=64'hFFFF_FFFF_8000_0000.
//  rd=0 or dst_vld=0, result 64'hDEAD -> rf_wen=0, rf_wdata=0, ifetch_req=1.
//  fu_sel=3'b000 and 3'b011 -> no fu_req, ill_sel+ifetch_req pulse, no write; stray fu_done[2] during LSU wait ignored.
//  idu_vld held high back-to-back -> idu_rdy low ISSUE..WB; each instruction issued exactly once; rst_n low in WAIT -> idle, no write.
//  EXU_TIMEOUT_EN, TIMEOUT_CYC=8, no fu_done -> exu_err+ifetch_req exactly 8 cycles into WAIT, no write.

Source files
------------

// File: rtl/exu_pkg.sv
// -----------------------------------------------------------------------------
// exu_pkg
// Shared types and constants for the execute-stage issue/writeback controller.
//   exu_state_e : controller state (IDLE -> ISSUE -> WAIT -> WB -> IDLE)
//   FU_ALU/FU_LSU/FU_SYS : functional-unit index within the one-hot select
// -----------------------------------------------------------------------------
package exu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } exu_state_e;

    localparam int FU_ALU = 0;
    localparam int FU_LSU = 1;
    localparam int FU_SYS = 2;

endpackage

// File: rtl/exu_wb_mux.sv
// -----------------------------------------------------------------------------
// exu_wb_mux
// Combinational writeback data path: picks the result slice of the selected
// functional unit and applies 32-bit W-op sign extension.
//   sel_i    : one-hot unit select (NUM_FU)
//   data_i   : packed unit results, unit i at [i*XLEN +: XLEN]
//   w_inst_i : sign-extend bit 31 of the result
//   data_o   : writeback data (XLEN)
// -----------------------------------------------------------------------------
module exu_wb_mux #(
    parameter int XLEN   = 64,
    parameter int NUM_FU = 3
) (
    input  logic [NUM_FU-1:0]      sel_i,
    input  logic [NUM_FU*XLEN-1:0] data_i,
    input  logic                   w_inst_i,
    output logic [XLEN-1:0]        data_o
);

    logic [XLEN-1:0] res_s;

    // AND-OR select of the unit slice, then optional W-op sign extension
    always_comb begin
        res_s = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (sel_i[i]) begin
                res_s = res_s | data_i[i*XLEN +: XLEN];
            end else begin
                res_s = res_s;
            end
        end
        if (w_inst_i) begin
            data_o = {{(XLEN-32){res_s[31]}}, res_s[31:0]};
        end else begin
            data_o = res_s;
        end
    end

endmodule

// File: rtl/exu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// exu_issue_ctrl
// Execute-stage issue/writeback controller. Accepts one decoded instruction
// from IDU (valid/ready), issues it to one functional unit, waits for that
// unit's completion, performs the single GPR write and pulses ifetch_req.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   idu_vld/idu_rdy       : instruction handshake (ready only in IDLE)
//   idu_rd/idu_dst_vld    : destination register and its write flag
//   idu_w_inst            : 32-bit W-op, sign-extend result bit 31
//   idu_fu_sel            : one-hot target unit
//   idu_pc                : instruction PC
//   fu_req                : one-cycle issue pulse to the selected unit
//   fu_pc                 : held PC of the in-flight instruction
//   fu_done/fu_wb_data    : unit completion pulses and packed results
//   rf_wen/waddr/wdata    : GPR write port
//   ifetch_req            : retire pulse
//   ill_sel               : pulse, fu_sel was not one-hot
//   exu_err               : pulse, watchdog abort
//
// Optional feature: define EXU_TIMEOUT_EN to enable the WAIT watchdog
// (limit TIMEOUT_CYC). Without it WAIT is unbounded and exu_err is tied 0.
// -----------------------------------------------------------------------------
module exu_issue_ctrl
    import exu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int REG_AW      = 5,
    parameter int NUM_FU      = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     idu_vld,
    output logic                     idu_rdy,
    input  logic [REG_AW-1:0]        idu_rd,
    input  logic                     idu_dst_vld,
    input  logic                     idu_w_inst,
    input  logic [NUM_FU-1:0]        idu_fu_sel,
    input  logic [XLEN-1:0]          idu_pc,
    output logic [NUM_FU-1:0]        fu_req,
    output logic [XLEN-1:0]          fu_pc,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic [NUM_FU*XLEN-1:0]   fu_wb_data,
    output logic                     rf_wen,
    output logic [REG_AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     ifetch_req,
    output logic                     ill_sel,
    output logic                     exu_err
);

    exu_state_e          state_q, state_d;

    // held instruction fields
    logic [REG_AW-1:0]   rd_q;
    logic                dst_vld_q;
    logic                w_inst_q;
    logic [NUM_FU-1:0]   fu_sel_q;
    logic [XLEN-1:0]     pc_q;

    // registered outputs
    logic [NUM_FU-1:0]   fu_req_q;
    logic                rf_wen_q;
    logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]     rf_wdata_q;
    logic                ifetch_req_q;
    logic                ill_sel_q;

    logic                accept_s;
    logic                sel_onehot_s;
    logic                done_hit_s;
    logic                expire_s;
    logic                fin_ok_s;
    logic                fin_ill_s;
    logic                fin_to_s;
    logic                rf_wen_d;
    logic [XLEN-1:0]     wb_data_s;

    assign accept_s     = (state_q == IDLE) && idu_vld;
    // x & (x-1) clears the lowest set bit; zero result plus non-zero x means one-hot
    assign sel_onehot_s = (idu_fu_sel != '0) &&
                          ((idu_fu_sel & (idu_fu_sel - NUM_FU'(1'b1))) == '0);
    // only the unit we issued to may complete the instruction
    assign done_hit_s   = |(fu_done & fu_sel_q);

`ifdef EXU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exu_err_q;

    assign expire_s = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // watchdog: zero outside WAIT so each WAIT visit starts counting from 0
    always_comb begin
        if (state_q != WAIT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    // watchdog counter and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            exu_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            exu_err_q <= fin_to_s;
        end
    end

    assign exu_err = exu_err_q;
`else
    logic unused_timeout_s;

    assign expire_s         = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYC > 32'sd0);
    assign exu_err          = 1'b0;
`endif

    // next-state logic; fin_* flag the cycle before WB and why we get there
    always_comb begin
        state_d   = state_q;
        fin_ok_s  = 1'b0;
        fin_ill_s = 1'b0;
        fin_to_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (sel_onehot_s) begin
                        state_d = ISSUE;
                    end else begin
                        state_d   = WB;
                        fin_ill_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (done_hit_s) begin
                    state_d  = WB;
                    fin_ok_s = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // completion beats an expiring watchdog in the same cycle
                if (done_hit_s) begin
                    state_d  = WB;
                    fin_ok_s = 1'b1;
                end else if (expire_s) begin
                    state_d  = WB;
                    fin_to_s = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    exu_wb_mux #(
        .XLEN   (XLEN),
        .NUM_FU (NUM_FU)
    ) u_wb_mux (
        .sel_i    (fu_sel_q),
        .data_i   (fu_wb_data),
        .w_inst_i (w_inst_q),
        .data_o   (wb_data_s)
    );

    // write decision and address for the upcoming WB cycle
    always_comb begin
        rf_wen_d = fin_ok_s && dst_vld_q && (rd_q != '0);
        if (fin_ill_s) begin
            // illegal select goes to WB straight from IDLE, fields not yet held
            rf_waddr_d = idu_rd;
        end else if (fin_ok_s || fin_to_s) begin
            rf_waddr_d = rd_q;
        end else begin
            rf_waddr_d = '0;
        end
    end

    // state, held fields and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_q         <= '0;
            dst_vld_q    <= 1'b0;
            w_inst_q     <= 1'b0;
            fu_sel_q     <= '0;
            pc_q         <= '0;
            fu_req_q     <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            ifetch_req_q <= 1'b0;
            ill_sel_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                rd_q      <= idu_rd;
                dst_vld_q <= idu_dst_vld;
                w_inst_q  <= idu_w_inst;
                fu_sel_q  <= idu_fu_sel;
                pc_q      <= idu_pc;
            end
            fu_req_q     <= (accept_s && sel_onehot_s) ? idu_fu_sel : '0;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wen_d ? wb_data_s : '0;
            ifetch_req_q <= fin_ok_s || fin_ill_s || fin_to_s;
            ill_sel_q    <= fin_ill_s;
        end
    end

    assign idu_rdy    = (state_q == IDLE);
    assign fu_req     = fu_req_q;
    assign fu_pc      = pc_q;
    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign ifetch_req = ifetch_req_q;
    assign ill_sel    = ill_sel_q;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exu_issue_ctrl
// Self-checking bench for exu_issue_ctrl. The stimulus process picks each
// instruction's completion latency up front, so the expected per-cycle
// outputs are scheduled into a cycle-indexed table at accept time.
// A negedge process compares every cycle against that table.
// Define EXU_TIMEOUT_EN to also cover the watchdog (TIMEOUT_CYC=8).
// -----------------------------------------------------------------------------
module tb_exu_issue_ctrl;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int NUM_FU = 3;
`ifdef EXU_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   idu_vld;
    logic                   idu_rdy;
    logic [REG_AW-1:0]      idu_rd;
    logic                   idu_dst_vld;
    logic                   idu_w_inst;
    logic [NUM_FU-1:0]      idu_fu_sel;
    logic [XLEN-1:0]        idu_pc;
    logic [NUM_FU-1:0]      fu_req;
    logic [XLEN-1:0]        fu_pc;
    logic [NUM_FU-1:0]      fu_done;
    logic [NUM_FU*XLEN-1:0] fu_wb_data;
    logic                   rf_wen;
    logic [REG_AW-1:0]      rf_waddr;
    logic [XLEN-1:0]        rf_wdata;
    logic                   ifetch_req;
    logic                   ill_sel;
    logic                   exu_err;

    always #5 clk = ~clk;

    exu_issue_ctrl #(
        .XLEN(XLEN), .REG_AW(REG_AW), .NUM_FU(NUM_FU), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .idu_vld(idu_vld), .idu_rdy(idu_rdy), .idu_rd(idu_rd),
        .idu_dst_vld(idu_dst_vld), .idu_w_inst(idu_w_inst),
        .idu_fu_sel(idu_fu_sel), .idu_pc(idu_pc),
        .fu_req(fu_req), .fu_pc(fu_pc), .fu_done(fu_done),
        .fu_wb_data(fu_wb_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ifetch_req(ifetch_req), .ill_sel(ill_sel), .exu_err(exu_err)
    );

    typedef struct packed {
        bit [2:0]  req;
        bit        busy;
        bit        ifr;
        bit        ill;
        bit        err;
        bit        wen;
        bit [4:0]  waddr;
        bit [63:0] wdata;
        bit        pcv;
        bit [63:0] pc;
    } exp_t;

    typedef struct packed {
        bit [2:0]  sel;
        bit [4:0]  rd;
        bit        dst;
        bit        w;
        bit [63:0] res;
        bit [63:0] pc;
        bit [7:0]  lat;
    } txn_t;

    exp_t      exp_q [int];
    int        cyc;
    int        checks;
    int        failures;
    bit        chk_en;
    int        free_at;
    int        done_cyc;
    int        mask_lo;
    int        mask_hi;
    bit [2:0]  mask_sel;
    bit [63:0] done_res;
    bit        force_stray;
    int        last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    function automatic exp_t get_exp(input int c);
        if (exp_q.exists(c)) return exp_q[c];
        return '0;
    endfunction

    // per-cycle comparison against the scheduled expectations
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            e = get_exp(cyc);
            chk("idu_rdy", 64'(idu_rdy), 64'(!e.busy));
            chk("fu_req", 64'(fu_req), 64'(e.req));
            if (e.pcv) chk("fu_pc", fu_pc, e.pc);
            chk("rf_wen", 64'(rf_wen), 64'(e.wen));
            if (e.wen) chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
            chk("rf_wdata", rf_wdata, e.wdata);
            chk("ifetch_req", 64'(ifetch_req), 64'(e.ifr));
            chk("ill_sel", 64'(ill_sel), 64'(e.ill));
            chk("exu_err", 64'(exu_err), 64'(e.err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // unit side: random results, occasional stray completions on other units
    task automatic set_bg();
        logic [2:0] stray;
        for (int i = 0; i < NUM_FU * 2; i++) fu_wb_data[i*32 +: 32] = $urandom;
        stray = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) stray = 3'b000;
        if (force_stray) stray = stray | 3'b100;
        if (cyc == done_cyc) begin
            fu_done = stray | mask_sel;
            for (int i = 0; i < NUM_FU; i++)
                if (mask_sel[i]) fu_wb_data[i*XLEN +: XLEN] = done_res;
        end else if (cyc >= mask_lo && cyc < mask_hi) begin
            fu_done = stray & ~mask_sel;
        end else begin
            fu_done = stray;
        end
    endtask

    task automatic rand_fields();
        idu_rd      = 5'($urandom);
        idu_dst_vld = 1'($urandom);
        idu_w_inst  = 1'($urandom);
        idu_fu_sel  = 3'($urandom);
        idu_pc      = {$urandom, $urandom};
    endtask

    // schedule the outputs an instruction accepted this cycle must produce
    task automatic plan(input txn_t t);
        int   c;
        int   wb;
        bit   to;
        exp_t e;
        c = cyc;
        if ($countones(t.sel) != 1) begin
            wb = c + 1;
            e = get_exp(wb); e.busy = 1; e.ifr = 1; e.ill = 1; exp_q[wb] = e;
            done_cyc = -1; mask_lo = -1; mask_hi = -1;
        end else begin
            to = TO_EN && (int'(t.lat) > TO);
            wb = to ? c + 2 + TO : c + 2 + int'(t.lat);
            e = get_exp(c + 1); e.req = t.sel; exp_q[c + 1] = e;
            for (int k = c + 1; k <= wb; k++) begin
                e = get_exp(k); e.busy = 1; e.pcv = 1; e.pc = t.pc; exp_q[k] = e;
            end
            e = get_exp(wb);
            e.ifr   = 1;
            e.err   = to;
            e.wen   = !to && t.dst && (t.rd != 5'd0);
            e.waddr = e.wen ? t.rd : 5'd0;
            e.wdata = !e.wen ? 64'd0 : (t.w ? 64'(signed'(t.res[31:0])) : t.res);
            exp_q[wb] = e;
            mask_sel = t.sel;
            mask_lo  = c + 1;
            mask_hi  = to ? wb : c + 1 + int'(t.lat);
            done_cyc = to ? -1 : c + 1 + int'(t.lat);
            done_res = t.res;
        end
        free_at  = wb + 1;
        last_acc = c;
    endtask

    task automatic send(input txn_t t, input bit hold);
        while (cyc < free_at) begin
            set_bg();
            idu_vld = hold ? 1'b1 : 1'($urandom_range(0, 1));
            rand_fields();
            tick();
        end
        set_bg();
        idu_vld     = 1'b1;
        idu_rd      = t.rd;
        idu_dst_vld = t.dst;
        idu_w_inst  = t.w;
        idu_fu_sel  = t.sel;
        idu_pc      = t.pc;
        plan(t);
        tick();
    endtask

    task automatic advance_to(input int c);
        while (cyc < c) begin
            set_bg();
            idu_vld = 1'b0;
            tick();
        end
    endtask

    // park on cycle c with stimulus applied, sampled at its negedge
    task automatic at_cycle(input int c);
        advance_to(c);
        set_bg();
        idu_vld = 1'b0;
        @(negedge clk);
    endtask

    function automatic txn_t mk(input bit [2:0] sel, input bit [4:0] rd, input bit dst,
                                input bit w, input bit [63:0] res, input int lat);
        txn_t t;
        t.sel = sel; t.rd = rd; t.dst = dst; t.w = w; t.res = res;
        t.pc = {$urandom, $urandom}; t.lat = 8'(lat);
        return t;
    endfunction

    initial begin
        int   keys[$];
        txn_t t;
        checks = 0; failures = 0; cyc = 0; chk_en = 1'b1;
        free_at = 0; done_cyc = -1; mask_lo = -1; mask_hi = -1; mask_sel = '0;
        done_res = '0; force_stray = 1'b0; last_acc = 0;
        rst_n = 1'b0; idu_vld = 1'b0; idu_rd = '0; idu_dst_vld = 1'b0; idu_w_inst = 1'b0;
        idu_fu_sel = '0; idu_pc = '0; fu_done = '0; fu_wb_data = '0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        free_at = cyc;

        // ALU, zero-latency completion in ISSUE
        send(mk(3'b001, 5'd5, 1'b1, 1'b0, 64'h1, 0), 1'b0);
        at_cycle(last_acc + 2);
        chk("lit_alu_wen", 64'(rf_wen), 64'd1);
        chk("lit_alu_waddr", 64'(rf_waddr), 64'd5);
        chk("lit_alu_wdata", rf_wdata, 64'h1);
        chk("lit_alu_ifetch", 64'(ifetch_req), 64'd1);
        tick();

        // LSU W-op load, done 7 cycles after fu_req, stray SYS completions meanwhile
        force_stray = 1'b1;
        send(mk(3'b010, 5'd3, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 7), 1'b0);
        at_cycle(last_acc + 9);
        chk("lit_lsu_wdata", rf_wdata, 64'hFFFF_FFFF_8000_0000);
        chk("lit_lsu_wen", 64'(rf_wen), 64'd1);
        tick();
        force_stray = 1'b0;

        // no write for rd=0 or dst_vld=0
        send(mk(3'b001, 5'd0, 1'b1, 1'b0, 64'hDEAD, 1), 1'b0);
        at_cycle(last_acc + 3);
        chk("lit_rd0_wen", 64'(rf_wen), 64'd0);
        chk("lit_rd0_wdata", rf_wdata, 64'd0);
        chk("lit_rd0_ifetch", 64'(ifetch_req), 64'd1);
        tick();
        send(mk(3'b100, 5'd7, 1'b0, 1'b0, 64'hDEAD, 2), 1'b0);

        // illegal selects
        send(mk(3'b000, 5'd9, 1'b1, 1'b0, 64'h0, 0), 1'b0);
        at_cycle(last_acc + 1);
        chk("lit_ill0_ill", 64'(ill_sel), 64'd1);
        chk("lit_ill0_ifetch", 64'(ifetch_req), 64'd1);
        chk("lit_ill0_req", 64'(fu_req), 64'd0);
        tick();
        send(mk(3'b011, 5'd9, 1'b1, 1'b0, 64'h0, 0), 1'b0);

        // back-to-back with idu_vld held high
        for (int i = 0; i < 4; i++) send(mk(3'b001, 5'(i + 1), 1'b1, 1'b0, 64'(i), i % 2), 1'b1);
        at_cycle(last_acc + 1);
        chk("lit_b2b_rdy", 64'(idu_rdy), 64'd0);
        chk("lit_b2b_req", 64'(fu_req), 64'd1);
        tick();

        // reset while waiting drops the instruction
        send(mk(3'b010, 5'd4, 1'b1, 1'b0, 64'h55, 10), 1'b0);
        advance_to(last_acc + 4);
        set_bg();
        idu_vld = 1'b0;
        rst_n = 1'b0;
        keys.delete();
        foreach (exp_q[k]) if (k >= cyc) keys.push_back(k);
        foreach (keys[i]) exp_q.delete(keys[i]);
        done_cyc = -1; mask_lo = -1; mask_hi = -1;
        tick(); tick();
        rst_n = 1'b1;
        free_at = cyc;

`ifdef EXU_TIMEOUT_EN
        send(mk(3'b010, 5'd6, 1'b1, 1'b0, 64'h77, 40), 1'b0);
        at_cycle(last_acc + 10);
        chk("lit_to_err", 64'(exu_err), 64'd1);
        chk("lit_to_ifetch", 64'(ifetch_req), 64'd1);
        chk("lit_to_wen", 64'(rf_wen), 64'd0);
        tick();
        send(mk(3'b010, 5'd6, 1'b1, 1'b0, 64'h77, 8), 1'b0);
        at_cycle(last_acc + 10);
        chk("lit_to_race_err", 64'(exu_err), 64'd0);
        chk("lit_to_race_wen", 64'(rf_wen), 64'd1);
        tick();
`endif

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) t.sel = 3'b001 << $urandom_range(0, 2);
            else t.sel = 3'($urandom);
            t.rd  = 5'($urandom);
            t.dst = ($urandom_range(0, 3) != 0);
            t.w   = 1'($urandom);
            t.res = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) t.res[31] = 1'b1;
            t.pc  = {$urandom, $urandom};
            t.lat = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 12)) : 8'($urandom_range(0, 3));
            send(t, 1'($urandom));
            if ($urandom_range(0, 4) == 0) advance_to(free_at + $urandom_range(0, 3));
        end

        advance_to(free_at + 3);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
